// File: rtl/ps2_pkg.sv
// Shared constants and decoder state encoding for the PS/2 keycode receiver.
// Also holds the frame validity rule so the receiver and any consumer agree on it.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_E0   = 2'd1,
    DEC_F0   = 2'd2,
    DEC_E0F0 = 2'd3
  } dec_state_e;

  // Start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic       start_bit,
                                    input logic [7:0] data,
                                    input logic       parity_bit,
                                    input logic       stop_bit);
    return !start_bit && stop_bit && (^{data, parity_bit});
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit shift and
// framing check, partial-frame timeout. Strobes are combinational on the processing cycle.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_o,
  output logic       good_o,
  output logic       bad_o
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [2:0]    clk_sync_q, data_sync_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fall, data_bit, frame_done, timeout;

  assign fall       = (clk_sync_q[2:1] == 2'b10);
  assign data_bit   = data_sync_q[2];
  assign frame_done = fall && (bit_cnt_q == LAST_BIT);
  // An edge in the same cycle always wins over the timeout.
  assign timeout    = (bit_cnt_q != 4'd0) && !fall &&
                      (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // After ten edges: shift_q[0] = start, shift_q[8:1] = D7..D0, shift_q[9] = parity.
  assign byte_o = shift_q[8:1];
  assign good_o = frame_done && frame_ok(shift_q[0], shift_q[8:1], shift_q[9], data_bit);
  assign bad_o  = (frame_done && !frame_ok(shift_q[0], shift_q[8:1], shift_q[9], data_bit))
                  || timeout;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = '0;
    if (fall) begin
      shift_d   = {data_bit, shift_q[9:1]};
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? 4'd0 : bit_cnt_q + 4'd1;
    end else if (timeout) begin
      bit_cnt_d = 4'd0;
    end else if (bit_cnt_q != 4'd0) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; synchronisers reset to the idle-high pin level.
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver top: prefix decoder FSM and held-key registers on top of
// the frame receiver. Drives the keycode bus consumed by the seven-segment display.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out,
  output logic       extended,
  output logic       valid,
  output logic       frame_err,
  output logic [7:0] key_count
);

  logic [7:0] rx_byte;
  logic       rx_good, rx_bad;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .byte_o  (rx_byte),
    .good_o  (rx_good),
    .bad_o   (rx_bad)
  );

  dec_state_e state_q, state_d;
  logic [7:0] out_q, out_d, count_q, count_d;
  logic       ext_q, ext_d, valid_q, valid_d, ferr_q, ferr_d;
  logic       do_make, do_brk, code_ext;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    ext_d    = ext_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    do_make  = 1'b0;
    do_brk   = 1'b0;
    code_ext = 1'b0;

    if (rx_bad) begin
      ferr_d  = 1'b1;
      state_d = DEC_IDLE;
    end else if (rx_good) begin
      state_d = DEC_IDLE;
      unique case (state_q)
        DEC_IDLE: begin
          if (rx_byte == PS2_PREFIX_EXT)      state_d = DEC_E0;
          else if (rx_byte == PS2_PREFIX_BRK) state_d = DEC_F0;
          else                                do_make = 1'b1;
        end
        DEC_E0: begin
          code_ext = 1'b1;
          if (rx_byte == PS2_PREFIX_BRK)      state_d = DEC_E0F0;
          else if (rx_byte == PS2_PREFIX_EXT) state_d = DEC_E0;
          else                                do_make = 1'b1;
        end
        DEC_F0:   do_brk = 1'b1;
        DEC_E0F0: begin
          do_brk   = 1'b1;
          code_ext = 1'b1;
        end
        default:  state_d = DEC_IDLE;
      endcase
    end

    // Code 00 is the keyboard's error report: never a key to hold or release.
    if (do_make && (rx_byte != 8'h00) && ((out_q != rx_byte) || (ext_q != code_ext))) begin
      out_d   = rx_byte;
      ext_d   = code_ext;
      count_d = count_q + 8'd1;
      valid_d = 1'b1;
    end
    if (do_brk && (rx_byte != 8'h00) && (out_q == rx_byte) && (ext_q == code_ext)) begin
      out_d   = 8'h00;
      ext_d   = 1'b0;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= DEC_IDLE;
      out_q   <= '0;
      ext_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ext_q   <= ext_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign out       = out_q;
  assign extended  = ext_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign key_count = count_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: scenario tasks plus randomized key traffic
// compared against a key-state model built from the make/break/prefix rules.
module tb_ps2_keycode_rx;

  localparam int TMO  = 2000;
  localparam int HALF = 3;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] out, key_count;
  logic       extended, valid, frame_err;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .out      (out),
    .extended (extended),
    .valid    (valid),
    .frame_err(frame_err),
    .key_count(key_count)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int valid_seen = 0, err_seen = 0, both_seen = 0;

  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (frame_err) err_seen++;
    if (valid && frame_err) both_seen++;
  end

  // Reference model: held key, pending prefixes, expected pulse totals.
  logic [7:0] m_code, m_count;
  logic       m_ext, m_pext, m_pbrk;
  int         m_pulses = 0, m_errs = 0;

  task automatic model_reset();
    m_code = 8'h00; m_ext = 1'b0; m_count = 8'h00; m_pext = 1'b0; m_pbrk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pbrk) begin
      if (b != 8'h00 && m_code == b && m_ext == m_pext) begin
        m_code = 8'h00; m_ext = 1'b0; m_pulses++;
      end
      m_pbrk = 1'b0; m_pext = 1'b0;
    end else if (b == 8'hE0) begin
      m_pext = 1'b1;
    end else if (b == 8'hF0) begin
      m_pbrk = 1'b1;
    end else begin
      if (b != 8'h00 && (m_code != b || m_ext != m_pext)) begin
        m_code = b; m_ext = m_pext; m_count = m_count + 8'd1; m_pulses++;
      end
      m_pext = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    tick(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    ps2_bits(frame, 11);
    tick(8);
    if (bad_par) begin
      m_errs++; m_pext = 1'b0; m_pbrk = 1'b0;
    end else begin
      model_byte(b);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    tick(3);
    clrn = 1'b1;
    model_reset();
    tick(2);
    checks++;
    if ({out, extended, key_count, valid, frame_err} !== 19'h0)
      $display("FAIL reset: out=%h ext=%b cnt=%h valid=%b ferr=%b expected all zero",
               out, extended, key_count, valid, frame_err);
    else passed++;
  endtask

  task automatic test_make_break();
    send(8'h1C, 1'b0);
    checks++;
    if ({out, extended, key_count} !== {8'h1C, 1'b0, 8'd1} || valid_seen != 1)
      $display("FAIL make_1C: out=%h ext=%b cnt=%0d pulses=%0d expected 1c/0/1/1",
               out, extended, key_count, valid_seen);
    else passed++;
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    checks++;
    if ({out, extended, key_count} !== {8'h00, 1'b0, 8'd1} || valid_seen != 2)
      $display("FAIL break_1C: out=%h ext=%b cnt=%0d pulses=%0d expected 00/0/1/2",
               out, extended, key_count, valid_seen);
    else passed++;
  endtask

  task automatic test_extended();
    logic [7:0] seq [8] = '{8'hE0, 8'h75, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h00};
    int         chk_at [3] = '{1, 3, 6};
    int         k = 0;
    for (int i = 0; i < 7; i++) begin
      send(seq[i], 1'b0);
      if (k < 3 && i == chk_at[k]) begin
        k++;
        checks++;
        if ({out, extended, key_count} !== {m_code, m_ext, m_count} || valid_seen != m_pulses)
          $display("FAIL extended_step%0d: out=%h ext=%b cnt=%0d pulses=%0d expected %h/%b/%0d/%0d",
                   i, out, extended, key_count, valid_seen, m_code, m_ext, m_count, m_pulses);
        else passed++;
      end
    end
    checks++;
    if ({out, extended} !== 9'h000)
      $display("FAIL extended_release: out=%h ext=%b expected 00/0", out, extended);
    else passed++;
  endtask

  task automatic test_typematic();
    int p0 = valid_seen;
    logic [7:0] c0 = key_count;
    repeat (5) send(8'h1C, 1'b0);
    checks++;
    if (out !== 8'h1C || valid_seen != p0 + 1 || key_count !== c0 + 8'd1)
      $display("FAIL typematic: out=%h pulses=%0d cnt=%0d expected 1c/%0d/%0d",
               out, valid_seen - p0, key_count, 1, c0 + 8'd1);
    else passed++;
    send(8'h32, 1'b0);
    checks++;
    if (out !== 8'h32 || key_count !== c0 + 8'd2 || valid_seen != m_pulses)
      $display("FAIL typematic_next: out=%h cnt=%0d expected 32/%0d", out, key_count, c0 + 8'd2);
    else passed++;
  endtask

  task automatic test_frame_error();
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b1);
    checks++;
    if (out !== 8'h32 || err_seen != m_errs || valid_seen != m_pulses)
      $display("FAIL parity_err: out=%h errs=%0d pulses=%0d expected 32/%0d/%0d",
               out, err_seen, valid_seen, m_errs, m_pulses);
    else passed++;
    send(8'h75, 1'b0);
    checks++;
    if ({out, extended} !== {8'h75, 1'b0})
      $display("FAIL err_clears_prefix: out=%h ext=%b expected 75/0", out, extended);
    else passed++;
    send(8'h1C, 1'b0);
    checks++;
    if ({out, extended, key_count} !== {m_code, m_ext, m_count} || err_seen != m_errs)
      $display("FAIL after_err: out=%h cnt=%0d errs=%0d expected %h/%0d/%0d",
               out, key_count, err_seen, m_code, m_count, m_errs);
    else passed++;
  endtask

  task automatic test_timeout();
    logic [10:0] frame = {1'b1, ~^8'h2A, 8'h2A, 1'b0};
    logic [7:0]  held = out;
    int          k = 0;
    ps2_bits(frame, 5);
    ps2_data = frame[5];
    tick(HALF);
    ps2_clk = 1'b0;
    while (!frame_err && k < TMO + 100) begin
      tick(1);
      k++;
      if (k == HALF) ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    checks++;
    if (k != TMO + 3)
      $display("FAIL timeout_latency: cycles=%0d expected %0d", k, TMO + 3);
    else passed++;
    tick(1);
    checks++;
    if (frame_err !== 1'b0 || out !== held)
      $display("FAIL timeout_pulse: ferr=%b out=%h expected 0/%h", frame_err, out, held);
    else passed++;
    m_errs++; m_pext = 1'b0; m_pbrk = 1'b0;
    send(8'h2A, 1'b0);
    checks++;
    if (out !== 8'h2A || err_seen != m_errs || key_count !== m_count)
      $display("FAIL after_timeout: out=%h errs=%0d cnt=%0d expected 2a/%0d/%0d",
               out, err_seen, key_count, m_errs, m_count);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] keys [5] = '{8'h1C, 8'h32, 8'h75, 8'h2A, 8'h6B};
    for (int i = 0; i < 40; i++) begin
      logic [7:0] key = keys[$urandom_range(4)];
      if ($urandom_range(2) == 0) send(8'hE0, 1'b0);
      if ($urandom_range(2) == 0) send(8'hF0, 1'b0);
      send(key, $urandom_range(9) == 0);
      tick($urandom_range(5));
      checks++;
      if ({out, extended, key_count} !== {m_code, m_ext, m_count} ||
          valid_seen != m_pulses || err_seen != m_errs)
        $display("FAIL random_%0d: out=%h ext=%b cnt=%0d pulses=%0d errs=%0d expected %h/%b/%0d/%0d/%0d",
                 i, out, extended, key_count, valid_seen, err_seen,
                 m_code, m_ext, m_count, m_pulses, m_errs);
      else passed++;
    end
  endtask

  task automatic test_wrap_and_reset();
    int e0;
    test_reset();
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32, 1'b0);
    checks++;
    if (key_count !== 8'h00 || out !== 8'h32 || valid_seen != m_pulses)
      $display("FAIL wrap: cnt=%0d out=%h pulses=%0d expected 0/32/%0d",
               key_count, out, valid_seen, m_pulses);
    else passed++;
    e0 = err_seen;
    ps2_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
    clrn = 1'b0;
    tick(2);
    clrn = 1'b1;
    model_reset();
    tick(TMO + 20);
    checks++;
    if ({out, extended, key_count, valid, frame_err} !== 19'h0 || err_seen != e0)
      $display("FAIL midframe_reset: out=%h cnt=%0d errs=%0d expected 00/0/%0d",
               out, key_count, err_seen - e0, 0);
    else passed++;
    send(8'h1C, 1'b0);
    checks++;
    if ({out, key_count} !== {8'h1C, 8'd1})
      $display("FAIL post_reset_frame: out=%h cnt=%0d expected 1c/1", out, key_count);
    else passed++;
  endtask

  task automatic test_no_overlap();
    checks++;
    if (both_seen != 0)
      $display("FAIL valid_ferr_overlap: cycles=%0d expected 0", both_seen);
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_frame_error();
    test_timeout();
    test_random();
    test_wrap_and_reset();
    test_no_overlap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
